// File: rtl/digpot_wiper_ctrl.sv
// ---------------------------------------------------------------------------
// digpot_wiper_ctrl
//
// Upstream sequencer for the digital-potentiometer pulse stage. It keeps track
// of where the wiper currently sits, accepts new target positions from the bus
// side, and turns each move into a step count plus a direction. It then runs a
// start/busy handshake with the pulse stage that does the actual stepping.
//
// Out of reset the wiper position is unknown, so the block first "homes" it.
// It issues an over-range down move that is guaranteed to pin the wiper at 0.
// Bus writes are buffered while that happens.
//
// Ports
//   clk_in       system clock, everything on the rising edge
//   reset        asynchronous, active-high reset
//   wr_en        one-cycle strobe: wr_data is a new target position
//   wr_data      requested wiper position (clamped to WIPER_MAX)
//   pulse_busy   pulse stage is stepping; its falling edge means "finished"
//   pulse_num    step count presented to the pulse stage
//   pulse_start  one-cycle start request to the pulse stage
//   dp_ud        step direction, 1 = up, 0 = down
//   dp_cs_n      digipot chip select, active low
//   pos          current wiper position (meaningful while pos_valid is high)
//   pos_valid    position is known: homing finished and no fault since
//   busy         a move is running or a target is waiting to be processed
//   done         one-cycle pulse at the end of every move, zero-step included
//   clamp_flag   last accepted target was above WIPER_MAX; held until next write
//   fault        handshake timed out; held until reset or a completed re-home
// ---------------------------------------------------------------------------
module digpot_wiper_ctrl #(
  parameter int WIPER_MAX   = 99,
  parameter int HOME_STEPS  = 110,
  parameter int SETUP_CYC   = 4,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  input  logic       pulse_busy,
  output logic [6:0] pulse_num,
  output logic       pulse_start,
  output logic       dp_ud,
  output logic       dp_cs_n,
  output logic [6:0] pos,
  output logic       pos_valid,
  output logic       busy,
  output logic       done,
  output logic       clamp_flag,
  output logic       fault
);

  // -------------------------------------------------------------------------
  // State encoding
  // -------------------------------------------------------------------------
  localparam logic [2:0] H_SETUP = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] WAIT_HI = 3'd2;
  localparam logic [2:0] WAIT_LO = 3'd3;
  localparam logic [2:0] SETTLE  = 3'd4;
  localparam logic [2:0] IDLE    = 3'd5;
  localparam logic [2:0] SETUP   = 3'd6;

  // One shared counter serves the setup hold, the settle hold and the two
  // handshake timeouts; it only has to be wide enough for the timeout.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  // H_SETUP drives its outputs from inside the state, so the first cycle
  // there is spent getting pulse_num/dp_ud onto the pins. One extra cycle
  // keeps the full SETUP_CYC hold time before pulse_start. SETUP gets its
  // values loaded on the way in from IDLE and needs no extra cycle.
  localparam logic [CNT_W-1:0] HSETUP_END  = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] SETUP_END   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_END  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [6:0] MAX_POS  = 7'(WIPER_MAX);
  localparam logic [6:0] HOME_NUM = 7'(HOME_STEPS);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             home_mode;
  logic [6:0]       tgt;
  logic [6:0]       pending;
  logic             pending_valid;

  // -------------------------------------------------------------------------
  // Write-side clamping: anything above the top of the wiper range is
  // pinned to WIPER_MAX, and that fact is reported through clamp_flag.
  // -------------------------------------------------------------------------
  logic       wr_over;
  logic [6:0] wr_clamped;

  assign wr_over    = (wr_data > MAX_POS);
  assign wr_clamped = wr_over ? MAX_POS : wr_data;

  // -------------------------------------------------------------------------
  // Move geometry for the target waiting in the pending register. The
  // differences are taken at 8 bits so that neither subtraction can wrap.
  // Both operands are at most WIPER_MAX, so the magnitude always fits back
  // into the 7-bit pulse_num.
  // -------------------------------------------------------------------------
  logic [7:0] diff_up;
  logic [7:0] diff_dn;
  logic       move_up;
  logic [6:0] move_num;

  assign diff_up  = {1'b0, pending} - {1'b0, pos};
  assign diff_dn  = {1'b0, pos} - {1'b0, pending};
  assign move_up  = (pending > pos);
  assign move_num = 7'(move_up ? diff_up : diff_dn);

  // -------------------------------------------------------------------------
  // Handshake-derived outputs. pulse_start is simply "we are in START", and
  // START always lasts exactly one cycle. busy stays high until the pending
  // register has been drained in IDLE.
  // -------------------------------------------------------------------------
  assign pulse_start = (state == START);
  assign busy        = (state != IDLE) || pending_valid;

  // -------------------------------------------------------------------------
  // Main sequencer.
  // The order of the blocks inside the clocked branch matters in one place.
  // The write capture sits after the FSM case. A write that lands in the
  // same cycle that IDLE drains the pending register therefore re-arms it
  // instead of being lost.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state         <= H_SETUP;
      cnt           <= '0;
      home_mode     <= 1'b0;
      tgt           <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      pulse_num     <= '0;
      dp_ud         <= 1'b0;
      dp_cs_n       <= 1'b1;
      pos           <= '0;
      pos_valid     <= 1'b0;
      done          <= 1'b0;
      clamp_flag    <= 1'b0;
      fault         <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state)
        // Homing: drive the wiper down by more than its full range, so it
        // ends at 0 from wherever it happened to be.
        H_SETUP: begin
          pulse_num <= HOME_NUM;
          dp_ud     <= 1'b0;
          dp_cs_n   <= 1'b0;
          home_mode <= 1'b1;
          if (cnt == HSETUP_END) begin
            state <= START;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Normal move: pulse_num/dp_ud were loaded on entry; just hold them.
        SETUP: begin
          if (cnt == SETUP_END) begin
            state <= START;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        START: begin
          state <= WAIT_HI;
          cnt   <= '0;
        end

        // The pulse stage has not answered in time. Release the chip
        // select, forget the position and re-home from scratch.
        WAIT_HI: begin
          if (pulse_busy) begin
            state <= WAIT_LO;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_END) begin
            fault     <= 1'b1;
            pos_valid <= 1'b0;
            dp_cs_n   <= 1'b1;
            state     <= H_SETUP;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_LO: begin
          if (!pulse_busy) begin
            state <= SETTLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_END) begin
            fault     <= 1'b1;
            pos_valid <= 1'b0;
            dp_cs_n   <= 1'b1;
            state     <= H_SETUP;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Keep the digipot selected while its wiper settles, then commit the
        // new position. A completed home is the only thing that clears fault.
        SETTLE: begin
          if (cnt == SETTLE_END) begin
            dp_cs_n   <= 1'b1;
            pos       <= home_mode ? 7'd0 : tgt;
            pos_valid <= 1'b1;
            if (home_mode) begin
              fault <= 1'b0;
            end
            done  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Drain the pending target. A target equal to the current position
        // completes immediately without touching the pulse stage.
        IDLE: begin
          if (pending_valid) begin
            pending_valid <= 1'b0;
            tgt           <= pending;
            if (pending == pos) begin
              done <= 1'b1;
            end else begin
              pulse_num <= move_num;
              dp_ud     <= move_up;
              dp_cs_n   <= 1'b0;
              home_mode <= 1'b0;
              state     <= SETUP;
              cnt       <= '0;
            end
          end
        end

        default: begin
          state <= H_SETUP;
          cnt   <= '0;
        end
      endcase

      // Writes are taken in every state. The last write wins.
      if (wr_en) begin
        pending       <= wr_clamped;
        pending_valid <= 1'b1;
        clamp_flag    <= wr_over;
      end
    end
  end

endmodule

// File: doc/digpot_wiper_ctrl.md
Name: digpot_wiper_ctrl

Overview:
- Upstream sequencer for the digital-potentiometer pulse stage.
- Accepts a target wiper position from the bus side and tracks the current wiper position.
- Computes step count and direction for each move, then drives the pulse stage with a start/busy handshake.
- On reset it homes the wiper with an over-range down move, so the position is known before any user move.

Parameters:
- WIPER_MAX, 99, highest legal wiper position; targets above it are clamped.
- HOME_STEPS, 110, step count used for the homing move (at least WIPER_MAX+1).
- SETUP_CYC, 4, cycles dp_ud and pulse_num are held stable before pulse_start.
- SETTLE_CYC, 8, cycles dp_cs_n stays low after the pulse stage finishes.
- TIMEOUT_CYC, 1023, maximum cycles spent in either wait state before fault.

Ports:
- clk_in  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  one-cycle target write strobe.
- wr_data  in  7  requested wiper position.
- pulse_busy  in  1  pulse stage busy; high while stepping, falling edge = done.
- pulse_num  out  7  step count to the pulse stage.
- pulse_start  out  1  one-cycle start request to the pulse stage.
- dp_ud  out  1  direction: 1 = up, 0 = down.
- dp_cs_n  out  1  digipot chip select, active low.
- pos  out  7  current wiper position (valid when pos_valid).
- pos_valid  out  1  position is known (homing complete, no fault).
- busy  out  1  move in progress or pending.
- done  out  1  one-cycle pulse when a move (including a zero-step move) completes.
- clamp_flag  out  1  last accepted target was clamped; sticky until the next wr_en.
- fault  out  1  handshake timeout; sticky until reset or a successful re-home.

Behaviour:
- Reset values: all outputs 0, except dp_cs_n=1, dp_ud=0, busy=1 (homing pending). FSM starts in H_SETUP.
- States: H_SETUP, START, WAIT_HI, WAIT_LO, SETTLE, IDLE, SETUP.
- H_SETUP
  - pulse_num=HOME_STEPS, dp_ud=0, dp_cs_n=0.
  - After SETUP_CYC cycles, go to START with home_mode=1.
- SETUP
  - pulse_num=|tgt-pos|, dp_ud=(tgt>pos), dp_cs_n=0.
  - Hold SETUP_CYC cycles, then go to START.
- START: pulse_start=1 for exactly one cycle, then go to WAIT_HI.
- WAIT_HI: wait for pulse_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for pulse_busy=0, then go to SETTLE.
- Timeout (WAIT_HI, WAIT_LO)
  - A cycle counter restarts on entry to each wait state.
  - Reaching TIMEOUT_CYC sets fault=1 and pos_valid=0, deasserts dp_cs_n, and goes to H_SETUP (re-home).
- SETTLE
  - Hold dp_cs_n=0 for SETTLE_CYC cycles, then set dp_cs_n=1.
  - Update position: pos=0 if home_mode, else pos=tgt. Set pos_valid=1. Clear fault if home_mode.
  - Pulse done=1 for one cycle, then go to IDLE.
- IDLE, busy=0:
  - If a pending target exists: load tgt from pending, set busy=1.
  - If tgt==pos: no handshake, done=1 next cycle, stay in IDLE.
  - Otherwise go to SETUP.
- Write handling
  - On wr_en the value clamps to min(wr_data, WIPER_MAX). clamp_flag = (wr_data>WIPER_MAX).
  - The clamped value goes into a 1-deep pending register; a later write overwrites it (last write wins).
  - Writes are accepted in any state. During homing they are held pending until homing completes.
- Width rules
  - Differences are computed in 8 bits; pulse_num is always ≤ WIPER_MAX during normal moves.
  - pos never exceeds WIPER_MAX.
- Simultaneous events
  - wr_en in the same cycle as SETTLE completion: the move completes first; the new target is processed from IDLE on the next cycle.
  - wr_en together with reset: reset wins.
- Reset mid-move: immediate return to reset values. The pulse stage is not aborted by this block; re-homing covers the unknown state.
- busy = (state≠IDLE) or pending_valid.

Test Plan:
- Release reset, pulse stage model answers busy 3..115 cycles after start → pulse_num=110, dp_ud=0, exactly one pulse_start, then pos=0, pos_valid=1, one done.
- After homing, write 40 → dp_ud=1, pulse_num=40, dp_ud stable ≥4 cycles before start, pos=40, done once.
- From pos=40, write 25 → dp_ud=0, pulse_num=15, pos=25. Then write 25 again → no pulse_start, done within 2 cycles.
- Write 120 → clamp_flag=1, pulse_num=74 from pos=25, final pos=99. Next write of 50 clears clamp_flag.
- During a move to 60, write 10 then 70 → only the 70 move follows, done pulses twice total, final pos=70.
- pulse_busy held 0 after start → fault=1 at 1023 cycles, pos_valid=0, re-home with pulse_num=110. Fault clears after the home completes.
